lagarto_store_buffer: RTL and testbench
=======================================

Name: lagarto_store_buffer

Overview:
- Committed-store FIFO between the Lagarto dcache interface store request outputs and the L1 data cache store port.
- Decouples store issue from cache grant latency, so the core retires stores without waiting on the cache.
- Flags loads that alias a pending store at 8-byte-word granularity, so the load path holds the load until the store drains.
- Provides an empty indication for fences and atomics.

Parameters:
DEPTH, 4, number of store entries; power of two, minimum 2
INDEX_W, 12, width of the cache index field (byte offset in bits [2:0])
TAG_W, 44, width of the physical tag field

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
st_valid_i  in  1  store request from dcache interface
st_index_i  in  INDEX_W  store address index
st_tag_i  in  TAG_W  store physical tag
st_wdata_i  in  64  store data, already lane-aligned
st_be_i  in  8  byte enables
st_size_i  in  2  access size (00 B, 01 H, 10 W, 11 D)
st_ready_o  out  1  buffer can accept a store this cycle
mem_req_valid_o  out  1  head store presented to cache
mem_req_index_o  out  INDEX_W  head index
mem_req_tag_o  out  TAG_W  head tag
mem_req_wdata_o  out  64  head data
mem_req_be_o  out  8  head byte enables
mem_req_size_o  out  2  head size
mem_req_we_o  out  1  constant 1
mem_req_tag_valid_o  out  1  equals mem_req_valid_o (tag is physical)
mem_gnt_i  in  1  cache accepted head store
ld_chk_index_i  in  INDEX_W  index of a load being issued
ld_chk_tag_i  in  TAG_W  tag of that load
ld_chk_valid_i  in  1  load check is valid
ld_conflict_o  out  1  load aliases a pending store
empty_o  out  1  no pending stores
count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: DEPTH entries of {index, tag, wdata, be, size}, plus head pointer, tail pointer and count register. Pointers wrap modulo DEPTH.
- Reset (async, rstn_i low): head=0, tail=0, count=0. Entry contents are don't-care.
- Reset output values: st_ready_o=1, mem_req_valid_o=0, mem_req_tag_valid_o=0, ld_conflict_o=0, empty_o=1, count_o=0. mem_req_we_o is always 1.
- Reset mid-operation discards all pending stores. Upstream must not assert rstn_i low while it relies on those stores completing.
- Enqueue:
  - Occurs when st_valid_i & st_ready_o; writes the entry at tail, tail+1.
  - st_ready_o = (count != DEPTH), a registered-state function only.
  - No ready bypass when full: a dequeue in the same cycle does not make room.
  - st_valid_i while not ready is dropped; upstream holds the request.
- Dequeue:
  - mem_req_valid_o = (count != 0). Payload outputs come from the head entry.
  - No empty bypass: a store enqueued in cycle N is presented no earlier than N+1.
  - Payload is stable while mem_req_valid_o=1 and mem_gnt_i=0.
  - Handshake completes on mem_req_valid_o & mem_gnt_i; head advances by 1 (head+1).
  - mem_gnt_i with mem_req_valid_o=0 is ignored.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal at any occupancy 1..DEPTH-1.
- Count arithmetic: count_next = count + enq - deq. It never exceeds DEPTH and never underflows. In simulation, assert on overflow or underflow.
- Conflict check (combinational):
  - ld_conflict_o = ld_chk_valid_i & (match of any occupied entry, OR match of the store being enqueued this cycle).
  - Match means tag equal AND index[INDEX_W-1:3] equal. Byte enables are ignored, so the check is conservative.
  - Only entries between head and tail are considered occupied, including the wrap-around case.
  - The head entry being granted this cycle still counts as a match.
- empty_o = (count == 0). count_o = count.
- Ordering: strict FIFO. There is no coalescing and no reordering.

Test Plan:
- Reset: hold rstn_i low mid-sim with 2 stores pending, release -> empty_o=1, count_o=0, mem_req_valid_o=0, st_ready_o=1.
- Fill/drain: 4 stores (index 0x010, 0x018, 0x020, 0x028, tag 0x1, data 0xA..0xD) with mem_gnt_i=0 -> count_o=4, st_ready_o=0, 5th store not accepted. Then mem_gnt_i=1 for 4 cycles -> data A, B, C, D presented in order, empty_o=1.
- Stall stability: head store presented, mem_gnt_i=0 for 5 cycles -> index, tag, wdata, be, size unchanged each cycle. Grant on cycle 6 -> next entry presented on cycle 7.
- Simultaneous enqueue and dequeue at count=2 for 10 cycles, pointers wrapping -> count_o stays 2 and FIFO order is preserved.
- Conflict:
  - Pending store index 0x123, tag 0x5. Load check index 0x121, tag 0x5 -> ld_conflict_o=1.
  - Load check index 0x12B, tag 0x5 -> 0.
  - Load check index 0x123, tag 0x6 -> 0.
  - Same-cycle enqueue of index 0x040 with check index 0x044 -> 1.
- Empty path: store enqueued in cycle N into empty buffer -> mem_req_valid_o=0 in cycle N and 1 in cycle N+1.

Source files
------------

// File: rtl/lagarto_store_buffer.sv
// lagarto_store_buffer
//
// FIFO of committed stores that sits between the dcache interface and the
// L1 data cache store port. The core retires a store as soon as it is
// written here; the buffer then presents stores to the cache one at a
// time, in strict FIFO order, as the cache grants them.
//
// Loads query the buffer combinationally. A load is flagged when it hits
// any pending store, or the store being written this cycle, in the same
// 8-byte word. This lets the load path hold the load until the store
// drains.
//
// Ports
//   clk_i, rstn_i        clock; asynchronous active-low reset
//   st_*_i, st_ready_o   store enqueue (valid/ready)
//   mem_req_*_o          head store presented to the cache
//   mem_gnt_i            cache accepted the head store
//   ld_chk_*_i           load address to check against pending stores
//   ld_conflict_o        load aliases a pending or incoming store
//   empty_o, count_o     occupancy status (used by fences and atomics)
module lagarto_store_buffer #(
  parameter int DEPTH   = 4,
  parameter int INDEX_W = 12,
  parameter int TAG_W   = 44
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               st_valid_i,
  input  logic [INDEX_W-1:0] st_index_i,
  input  logic [TAG_W-1:0]   st_tag_i,
  input  logic [63:0]        st_wdata_i,
  input  logic [7:0]         st_be_i,
  input  logic [1:0]         st_size_i,
  output logic               st_ready_o,
  output logic               mem_req_valid_o,
  output logic [INDEX_W-1:0] mem_req_index_o,
  output logic [TAG_W-1:0]   mem_req_tag_o,
  output logic [63:0]        mem_req_wdata_o,
  output logic [7:0]         mem_req_be_o,
  output logic [1:0]         mem_req_size_o,
  output logic               mem_req_we_o,
  output logic               mem_req_tag_valid_o,
  input  logic               mem_gnt_i,
  input  logic [INDEX_W-1:0] ld_chk_index_i,
  input  logic [TAG_W-1:0]   ld_chk_tag_i,
  input  logic               ld_chk_valid_i,
  output logic               ld_conflict_o,
  output logic               empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INDEX_W-1:0] idx_mem  [DEPTH];
  logic [TAG_W-1:0]   tag_mem  [DEPTH];
  logic [63:0]        data_mem [DEPTH];
  logic [7:0]         be_mem   [DEPTH];
  logic [1:0]         size_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic enq;
  logic deq;
  logic hit;
  logic [PTR_W-1:0] offs [DEPTH];

  // Byte-offset bits of the load index never take part in the word match.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_chk_index_i[2:0];

  // Ready and valid depend only on registered state: no bypass in either direction.
  assign st_ready_o          = (count != CNT_W'(DEPTH));
  assign mem_req_valid_o     = (count != '0);
  assign mem_req_tag_valid_o = mem_req_valid_o;
  assign mem_req_we_o        = 1'b1;
  assign empty_o             = (count == '0);
  assign count_o             = count;

  assign enq = st_valid_i & st_ready_o;
  assign deq = mem_req_valid_o & mem_gnt_i;

  assign count_next = count + CNT_W'(enq) - CNT_W'(deq);

  assign mem_req_index_o = idx_mem[head];
  assign mem_req_tag_o   = tag_mem[head];
  assign mem_req_wdata_o = data_mem[head];
  assign mem_req_be_o    = be_mem[head];
  assign mem_req_size_o  = size_mem[head];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count <= count_next;
    end
  end

  // Entry payload carries no reset; occupancy is tracked by head/count.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      idx_mem[tail]  <= st_index_i;
      tag_mem[tail]  <= st_tag_i;
      data_mem[tail] <= st_wdata_i;
      be_mem[tail]   <= st_be_i;
      size_mem[tail] <= st_size_i;
    end
  end

  // An entry is occupied when its distance from head (mod DEPTH) is below
  // count; this covers the wrapped case and the full case alike. The head
  // entry being granted this cycle is still occupied and still matches.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offs[i] = PTR_W'(i) - head;
      if (({1'b0, offs[i]} < count) &&
          (tag_mem[i] == ld_chk_tag_i) &&
          (idx_mem[i][INDEX_W-1:3] == ld_chk_index_i[INDEX_W-1:3]))
        hit = 1'b1;
    end
    if (enq && (st_tag_i == ld_chk_tag_i) &&
        (st_index_i[INDEX_W-1:3] == ld_chk_index_i[INDEX_W-1:3]))
      hit = 1'b1;
  end

  assign ld_conflict_o = ld_chk_valid_i & hit;

  always @(posedge clk_i) begin
    if (rstn_i) begin
      assert (!(deq && (count == '0)));
      assert (!(enq && !deq && (count == CNT_W'(DEPTH))));
      assert (count_next <= CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_lagarto_store_buffer.sv
module tb_lagarto_store_buffer;

  localparam int DEPTH   = 4;
  localparam int INDEX_W = 12;
  localparam int TAG_W   = 44;

  typedef struct {
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [63:0]        data;
    logic [7:0]         be;
    logic [1:0]         size;
  } ent_t;

  logic               clk;
  logic               rstn;
  logic               st_valid;
  logic [INDEX_W-1:0] st_index;
  logic [TAG_W-1:0]   st_tag;
  logic [63:0]        st_wdata;
  logic [7:0]         st_be;
  logic [1:0]         st_size;
  logic               st_ready;
  logic               mem_req_valid;
  logic [INDEX_W-1:0] mem_req_index;
  logic [TAG_W-1:0]   mem_req_tag;
  logic [63:0]        mem_req_wdata;
  logic [7:0]         mem_req_be;
  logic [1:0]         mem_req_size;
  logic               mem_req_we;
  logic               mem_req_tag_valid;
  logic               mem_gnt;
  logic [INDEX_W-1:0] ld_chk_index;
  logic [TAG_W-1:0]   ld_chk_tag;
  logic               ld_chk_valid;
  logic               ld_conflict;
  logic               empty;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  ent_t q[$];

  lagarto_store_buffer #(.DEPTH(DEPTH), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .st_valid_i(st_valid), .st_index_i(st_index), .st_tag_i(st_tag),
    .st_wdata_i(st_wdata), .st_be_i(st_be), .st_size_i(st_size),
    .st_ready_o(st_ready),
    .mem_req_valid_o(mem_req_valid), .mem_req_index_o(mem_req_index),
    .mem_req_tag_o(mem_req_tag), .mem_req_wdata_o(mem_req_wdata),
    .mem_req_be_o(mem_req_be), .mem_req_size_o(mem_req_size),
    .mem_req_we_o(mem_req_we), .mem_req_tag_valid_o(mem_req_tag_valid),
    .mem_gnt_i(mem_gnt),
    .ld_chk_index_i(ld_chk_index), .ld_chk_tag_i(ld_chk_tag),
    .ld_chk_valid_i(ld_chk_valid), .ld_conflict_o(ld_conflict),
    .empty_o(empty), .count_o(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: whenever a store is presented, it must equal the oldest
  // expected store; it is retired from the scoreboard when granted.
  always @(negedge clk) begin
    if (rstn && mem_req_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=valid index=%h required=no store", mem_req_index);
      end else begin
        chk("req_index", 64'(mem_req_index), 64'(q[0].idx));
        chk("req_tag",   64'(mem_req_tag),   64'(q[0].tag));
        chk("req_wdata", mem_req_wdata,      q[0].data);
        chk("req_be",    64'(mem_req_be),    64'(q[0].be));
        chk("req_size",  64'(mem_req_size),  64'(q[0].size));
        chk("req_we_tv", 64'({mem_req_we, mem_req_tag_valid}), 64'(2'b11));
        if (mem_gnt) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a store for the coming edge; when acc is set it is expected to
  // be accepted and goes into the scoreboard.
  task automatic drive_st(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                          input logic [63:0] data, input logic [7:0] be,
                          input logic [1:0] size, input bit acc);
    ent_t e;
    st_valid = 1'b1;
    st_index = idx;
    st_tag   = tag;
    st_wdata = data;
    st_be    = be;
    st_size  = size;
    e.idx = idx; e.tag = tag; e.data = data; e.be = be; e.size = size;
    if (acc) q.push_back(e);
  endtask

  task automatic ld_chk(input string nm, input logic [INDEX_W-1:0] idx,
                        input logic [TAG_W-1:0] tag, input logic exp);
    ld_chk_valid = 1'b1;
    ld_chk_index = idx;
    ld_chk_tag   = tag;
    #1;
    chk(nm, 64'(ld_conflict), 64'(exp));
    ld_chk_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    st_valid = 1'b0; st_index = '0; st_tag = '0; st_wdata = '0; st_be = '0; st_size = '0;
    mem_gnt = 1'b0; ld_chk_index = '0; ld_chk_tag = '0; ld_chk_valid = 1'b0;
    repeat (2) tick();
    #1;
    chk("rst_empty",    64'(empty), 64'd1);
    chk("rst_count",    64'(count), 64'd0);
    chk("rst_valid",    64'(mem_req_valid), 64'd0);
    chk("rst_tagvalid", 64'(mem_req_tag_valid), 64'd0);
    chk("rst_ready",    64'(st_ready), 64'd1);
    chk("rst_conflict", 64'(ld_conflict), 64'd0);
    chk("rst_we",       64'(mem_req_we), 64'd1);
    rstn = 1'b1;

    // Fill to full, fifth store refused, then drain in order.
    for (int k = 0; k < 4; k++) begin
      tick();
      drive_st(12'h010 + 12'(8 * k), 44'h1, 64'hA + 64'(k), 8'hFF, 2'b11, 1'b1);
    end
    tick();
    drive_st(12'h030, 44'h1, 64'hE, 8'hFF, 2'b11, 1'b0);
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(st_ready), 64'd0);
    tick();
    st_valid = 1'b0;
    chk("fifth_dropped_count", 64'(count), 64'd4);
    mem_gnt = 1'b1;
    repeat (4) tick();
    mem_gnt = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_q", 64'(q.size()), 64'd0);

    // Stall stability: head held 5 cycles, granted on the 6th.
    tick();
    drive_st(12'h100, 44'h2, 64'h11, 8'hFF, 2'b11, 1'b1);
    tick();
    drive_st(12'h108, 44'h3, 64'h22, 8'h0F, 2'b10, 1'b1);
    tick();
    st_valid = 1'b0;
    repeat (5) tick();
    chk("stall_count", 64'(count), 64'd2);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("stall_next_data", mem_req_wdata, 64'h22);
    chk("stall_next_be", 64'(mem_req_be), 64'h0F);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("stall_empty", 64'(empty), 64'd1);

    // Simultaneous enqueue/dequeue at count=2 across pointer wrap.
    tick();
    drive_st(12'h200, 44'h7, 64'h30, 8'hFF, 2'b11, 1'b1);
    tick();
    drive_st(12'h208, 44'h7, 64'h31, 8'hFF, 2'b11, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      drive_st(12'h210 + 12'(8 * k), 44'h7, 64'h32 + 64'(k), 8'hFF, 2'b11, 1'b1);
      mem_gnt = 1'b1;
      #1;
      chk("simul_count", 64'(count), 64'd2);
    end
    tick();
    st_valid = 1'b0;
    repeat (2) tick();
    mem_gnt = 1'b0;
    chk("simul_empty", 64'(empty), 64'd1);
    chk("simul_q", 64'(q.size()), 64'd0);

    // Conflict detection.
    tick();
    drive_st(12'h123, 44'h5, 64'h55, 8'h08, 2'b00, 1'b1);
    tick();
    st_valid = 1'b0;
    ld_chk("conf_same_word", 12'h121, 44'h5, 1'b1);
    ld_chk("conf_next_word", 12'h12B, 44'h5, 1'b0);
    ld_chk("conf_other_tag", 12'h123, 44'h6, 1'b0);
    drive_st(12'h040, 44'h5, 64'h66, 8'hF0, 2'b10, 1'b1);
    ld_chk("conf_enq_bypass", 12'h044, 44'h5, 1'b1);
    ld_chk_valid = 1'b0;
    ld_chk_index = 12'h123;
    ld_chk_tag = 44'h5;
    #1;
    chk("conf_chk_invalid", 64'(ld_conflict), 64'd0);
    tick();
    st_valid = 1'b0;
    mem_gnt = 1'b1;
    ld_chk("conf_head_granting", 12'h123, 44'h5, 1'b1);
    tick();
    tick();
    mem_gnt = 1'b0;
    chk("conf_drained", 64'(empty), 64'd1);
    ld_chk("conf_stale_entry", 12'h123, 44'h5, 1'b0);

    // No empty bypass.
    tick();
    drive_st(12'h300, 44'h9, 64'h77, 8'hFF, 2'b11, 1'b1);
    #1;
    chk("nobypass_cycle_n", 64'(mem_req_valid), 64'd0);
    tick();
    st_valid = 1'b0;
    #1;
    chk("nobypass_cycle_n1", 64'(mem_req_valid), 64'd1);

    // Reset with two stores pending discards them.
    tick();
    drive_st(12'h310, 44'h9, 64'h78, 8'hFF, 2'b11, 1'b1);
    tick();
    st_valid = 1'b0;
    #1;
    chk("prerst_count", 64'(count), 64'd2);
    rstn = 1'b0;
    q.delete();
    #1;
    chk("midrst_empty", 64'(empty), 64'd1);
    repeat (2) tick();
    rstn = 1'b1;
    #1;
    chk("postrst_empty", 64'(empty), 64'd1);
    chk("postrst_count", 64'(count), 64'd0);
    chk("postrst_valid", 64'(mem_req_valid), 64'd0);
    chk("postrst_ready", 64'(st_ready), 64'd1);

    // Still functional after reset.
    tick();
    drive_st(12'h400, 44'hA, 64'h99, 8'h01, 2'b00, 1'b1);
    tick();
    st_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("final_empty", 64'(empty), 64'd1);
    chk("final_q", 64'(q.size()), 64'd0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
